// File: rtl/dilithium_pkg.sv
// Shared constants, mode encodings and FSM states for the poly stream I/O path.
// Word layout: coefficient 4k+j sits in word k at bits [24j+23:24j].
package dilithium_pkg;

  localparam int COEFF_W = 24;
  localparam int LANES   = 4;
  localparam int DEPTH   = 64;
  localparam int Q       = 8380417;

  localparam int WORD_W = LANES * COEFF_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(LANES * DEPTH);

  localparam logic [CW-1:0] LAST_COEFF = CW'(LANES * DEPTH - 1);
  localparam logic [AW-1:0] LAST_WORD  = AW'(DEPTH - 1);

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_UNLOAD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UNLOAD_PRIME,
    UNLOAD,
    FINISH
  } state_t;

endpackage

// File: rtl/poly_stream_io_word_skid_buffer.sv
// word_skid_buffer: 2-entry FIFO of BRAM words used on the UNLOAD path.
// Entry 0 is always the head; push and pop may happen in the same cycle.
module word_skid_buffer
  import dilithium_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [WORD_W-1:0] din_i,
  output logic [WORD_W-1:0] head_o,
  output logic [1:0]        count_o,
  output logic              space_o
);

  logic [WORD_W-1:0] e0_q, e1_q;
  logic [1:0]        cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= din_i;
          else               e1_q <= din_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= din_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = e0_q;
  assign count_o = cnt_q;
  assign space_o = (cnt_q != 2'd2);

endmodule

// File: rtl/poly_stream_io.sv
// poly_stream_io: packs a coefficient stream into BRAM words and back again.
// Optional sticky range check on loaded data: POLY_STREAM_IO_RANGE_CHECK_EN.
module poly_stream_io
  import dilithium_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  output logic               done,
  output logic               busy,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COEFF_W-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [COEFF_W-1:0] m_data,
  output logic               m_last,
  output logic [AW-1:0]      addra,
  input  logic [WORD_W-1:0]  doa,
  output logic [AW-1:0]      addrb,
  output logic               web,
  output logic [WORD_W-1:0]  dib,
  output logic               range_err
);

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [3*COEFF_W-1:0]   pack_q;
  logic                   s_ready_q, busy_q, done_q, web_q;
  logic [AW-1:0]          addrb_q, addra_q, raddr_q;
  logic [WORD_W-1:0]      dib_q;
  logic                   s1_q, s2_q, rd_last_q;

  logic [WORD_W-1:0]  head, word_sel;
  logic [1:0]         buf_cnt;
  logic               buf_space;
  logic [COEFF_W-1:0] lane;
  logic [2:0]         occ;
  logic               hs_in, hs_out, pop, issue, mv, accept;

  assign accept = (state_q == IDLE) && start;
  assign hs_in  = s_valid && s_ready_q;
  assign mv     = (state_q == UNLOAD) && ((buf_cnt != 2'd0) || s2_q);
  assign hs_out = mv && m_ready;
  assign pop    = hs_out && (cnt_q[1:0] == 2'd3) && (buf_cnt != 2'd0);

  // words held plus reads still in flight, net of this cycle's pop
  assign occ = {1'b0, buf_cnt} + {2'b0, s1_q} + {2'b0, s2_q}
             - {2'b0, pop};

  assign issue = ((state_q == UNLOAD_PRIME) || (state_q == UNLOAD))
              && !rd_last_q && (occ < 3'd2) && (buf_space || pop);

  // empty buffer: the word arriving from BRAM falls straight through
  assign word_sel = (buf_cnt != 2'd0) ? head : doa;
  assign lane     = word_sel[cnt_q[1:0]*COEFF_W +: COEFF_W];

  word_skid_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept),
    .push_i  (s2_q),
    .pop_i   (pop),
    .din_i   (doa),
    .head_o  (head),
    .count_o (buf_cnt),
    .space_o (buf_space)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pack_q    <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      web_q     <= 1'b0;
      addrb_q   <= '0;
      dib_q     <= '0;
      addra_q   <= '0;
      raddr_q   <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      web_q  <= 1'b0;
      done_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= s1_q;
      if (issue) begin
        addra_q   <= raddr_q;
        raddr_q   <= raddr_q + AW'(1);
        s1_q      <= 1'b1;
        rd_last_q <= (raddr_q == LAST_WORD);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (mode == MODE_LOAD) begin
              state_q   <= LOAD;
              s_ready_q <= 1'b1;
            end else begin
              state_q   <= UNLOAD_PRIME;
              addra_q   <= '0;
              raddr_q   <= AW'(1);
              s1_q      <= 1'b1;
              rd_last_q <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (!s_ready_q) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else if (hs_in) begin
            pack_q <= {s_data, pack_q[3*COEFF_W-1:COEFF_W]};
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q[1:0] == 2'd3) begin
              web_q   <= 1'b1;
              addrb_q <= cnt_q[CW-1:2];
              dib_q   <= {s_data, pack_q};
            end
            if (cnt_q == LAST_COEFF) s_ready_q <= 1'b0;
          end
        end
        UNLOAD_PRIME: state_q <= UNLOAD;
        UNLOAD: begin
          if (hs_out) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_COEFF) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef POLY_STREAM_IO_RANGE_CHECK_EN
  logic range_q;

  always_ff @(posedge clk) begin
    if (rst || accept)
      range_q <= 1'b0;
    else if (hs_in && (s_data >= COEFF_W'(Q)))
      range_q <= 1'b1;
  end

  assign range_err = range_q;
`else
  assign range_err = 1'b0;
`endif

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign web     = web_q;
  assign addrb   = addrb_q;
  assign dib     = dib_q;
  assign addra   = addra_q;
  assign m_valid = mv;
  assign m_data  = mv ? lane : '0;
  assign m_last  = mv && (cnt_q == LAST_COEFF);

endmodule
